// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - phase-accumulator oscillator with square/saw/triangle/off waveforms
module wave_generator #(
  parameter int M = 6,
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_en,
  input  logic         sync,
  input  logic [M-1:0] incr,
  input  logic [1:0]   mode,
  input  logic [M-1:0] duty,
  output logic [N-1:0] wave,
  output logic         valid
);

  localparam logic [1:0]   MODE_SQUARE = 2'd0;
  localparam logic [1:0]   MODE_SAW    = 2'd1;
  localparam logic [1:0]   MODE_TRI    = 2'd2;
  localparam logic [1:0]   MODE_OFF    = 2'd3;
  localparam logic [M-1:0] DUTY_HALF   = {1'b1, {(M-1){1'b0}}};

  logic [M-1:0] phase;
  logic [1:0]   mode_q;
  logic [M-1:0] duty_q;

  logic [M:0]   sum;
  logic         wrap;
  logic         reload;
  logic [M-1:0] phase_next;
  logic [1:0]   mode_next;
  logic [M-1:0] duty_next;
  logic [M-2:0] tri_t;
  logic [N-1:0] saw_w;
  logic [N-1:0] tri_w;
  logic [N-1:0] sample;

  always_comb begin
    sum    = {1'b0, phase} + {1'b0, incr};
    wrap   = sum[M];
    // An idle (off) channel reloads on any strobe so it can start without waiting for a wrap.
    reload = sync | (sample_en & (wrap | (mode_q == MODE_OFF)));

    if (sync)
      phase_next = '0;
    else if (sample_en)
      phase_next = sum[M-1:0];
    else
      phase_next = phase;

    mode_next = reload ? mode : mode_q;
    duty_next = reload ? duty : duty_q;

    saw_w = N'(phase_next) << (N - M);
    tri_t = phase_next[M-1] ? ~phase_next[M-2:0] : phase_next[M-2:0];
    tri_w = N'(tri_t) << (N - M + 1);

    case (mode_next)
      MODE_SQUARE: sample = (phase_next >= duty_next) ? '1 : '0;
      MODE_SAW:    sample = saw_w;
      MODE_TRI:    sample = tri_w;
      default:     sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      mode_q <= MODE_OFF;
      duty_q <= DUTY_HALF;
      wave   <= '0;
      valid  <= 1'b0;
    end else begin
      phase  <= phase_next;
      mode_q <= mode_next;
      duty_q <= duty_next;
      if (sample_en | sync) begin
        wave  <= sample;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// tb/tb_wave_generator.sv - randomized and directed checks of wave_generator against an arithmetic model
module tb_wave_generator;

  localparam int M = 6;
  localparam int N = 11;
  localparam int P = 1 << M;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_en;
  logic         sync;
  logic [M-1:0] incr;
  logic [1:0]   mode;
  logic [M-1:0] duty;
  logic [N-1:0] wave;
  logic         valid;

  int vectors = 0;
  int miscompares = 0;

  int m_phase, m_mode, m_duty, m_wave, m_valid;

  wave_generator #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sync(sync),
    .incr(incr), .mode(mode), .duty(duty), .wave(wave), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int p, input int md, input int d);
    case (md)
      0:       return (p >= d) ? (1 << N) - 1 : 0;
      1:       return p * (1 << (N - M));
      2:       return ((p < P / 2) ? p : P - 1 - p) * (1 << (N - M + 1));
      default: return 0;
    endcase
  endfunction

  // Reference behaviour applied at each rising edge using the inputs presented before it.
  task automatic model_edge();
    int s;
    if (rst) begin
      m_phase = 0; m_mode = 3; m_duty = P / 2; m_wave = 0; m_valid = 0;
    end else if (sync) begin
      m_phase = 0; m_mode = int'(mode); m_duty = int'(duty);
      m_wave = shape(m_phase, m_mode, m_duty); m_valid = 1;
    end else if (sample_en) begin
      s = m_phase + int'(incr);
      m_phase = s % P;
      if (s >= P || m_mode == 3) begin
        m_mode = int'(mode); m_duty = int'(duty);
      end
      m_wave = shape(m_phase, m_mode, m_duty); m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit e, input int i, input int md, input int d);
    rst = r; sync = s; sample_en = e;
    incr = M'(i); mode = 2'(md); duty = M'(d);
    @(posedge clk);
    model_edge();
    #1;
    chk("wave", int'(wave), m_wave);
    chk("valid", int'(valid), m_valid);
  endtask

  initial begin
    m_phase = 0; m_mode = 3; m_duty = P / 2; m_wave = 0; m_valid = 0;

    for (int k = 0; k < 3; k++)
      cyc(1, $urandom_range(1), $urandom_range(1), $urandom, $urandom, $urandom);
    chk("rst_wave", int'(wave), 0);
    chk("rst_valid", int'(valid), 0);

    // Off mode after reset reloads square on the very first strobe.
    for (int k = 1; k <= 64; k++) begin
      cyc(0, 0, 1, 1, 0, 32);
      chk("square_lit", int'(wave), ((k % 64) >= 32) ? 'h7FF : 'h000);
      chk("square_valid", int'(valid), 1);
    end

    cyc(0, 1, 0, 4, 1, 0);
    cyc(0, 0, 1, 4, 1, 0);
    chk("saw_p4", int'(wave), 'h080);
    for (int k = 0; k < 14; k++) cyc(0, 0, 1, 4, 1, 0);
    chk("saw_p60", int'(wave), 'h780);
    cyc(0, 0, 1, 4, 1, 0);
    chk("saw_wrap", int'(wave), 'h000);

    cyc(0, 1, 0, 1, 2, 0);
    for (int k = 1; k <= 63; k++) begin
      cyc(0, 0, 1, 1, 2, 0);
      if (k == 16) chk("tri_p16", int'(wave), 'h400);
      if (k == 31) chk("tri_p31", int'(wave), 'h7C0);
      if (k == 32) chk("tri_p32", int'(wave), 'h7C0);
      if (k == 63) chk("tri_p63", int'(wave), 'h000);
    end

    cyc(0, 1, 0, 4, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 4, 1, 0);
    for (int p = 24; p <= 60; p += 4) begin
      cyc(0, 0, 1, 4, 0, 16);
      chk("switch_saw", int'(wave), p * 32);
    end
    cyc(0, 0, 1, 4, 0, 16);
    chk("switch_wrap", int'(wave), 'h000);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 4, 0, 16);
    chk("switch_p16", int'(wave), 'h7FF);

    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 4, 0, 16);
    cyc(0, 1, 1, 4, 1, 0);
    chk("sync_valid", int'(valid), 1);
    chk("sync_wave", int'(wave), 'h000);
    cyc(0, 0, 1, 4, 3, 0);
    chk("sync_reload", int'(wave), 'h080);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 4, 3, 0);
      chk("gap_valid", int'(valid), 0);
      chk("gap_wave", int'(wave), 'h080);
    end
    cyc(0, 0, 1, 4, 3, 0);
    chk("gap_resume", int'(wave), 'h100);
    cyc(0, 0, 1, 0, 3, 0);
    chk("incr0_valid", int'(valid), 1);
    chk("incr0_wave", int'(wave), 'h100);

    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(49) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
          ($urandom_range(7) == 0) ? 0 : $urandom, $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
